// File: rtl/bus_pkg.sv
// Shared types and default address map for the single-master bus fabric.
// Slave order of the default map: 0 BRAM, 1 SPRAM, 2 LED, 3 UART.
package bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_N  = 4;

    localparam logic [DEF_AW-1:0] BRAM_BASE  = 16'h0000;
    localparam logic [DEF_AW-1:0] BRAM_MASK  = 16'hC000;
    localparam logic [DEF_AW-1:0] SPRAM_BASE = 16'h8000;
    localparam logic [DEF_AW-1:0] SPRAM_MASK = 16'h8000;
    localparam logic [DEF_AW-1:0] LED_BASE   = 16'h4000;
    localparam logic [DEF_AW-1:0] LED_MASK   = 16'hF000;
    localparam logic [DEF_AW-1:0] UART_BASE  = 16'h5000;
    localparam logic [DEF_AW-1:0] UART_MASK  = 16'hF000;

    localparam logic [DEF_N*DEF_AW-1:0] DEF_BASE = {
        UART_BASE, LED_BASE, SPRAM_BASE, BRAM_BASE
    };
    localparam logic [DEF_N*DEF_AW-1:0] DEF_MASK = {
        UART_MASK, LED_MASK, SPRAM_MASK, BRAM_MASK
    };

    function automatic int cnt_w(input int t);
        return $clog2(t + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_decode.sv
// Base/mask address match with lowest-index priority.
// Produces a hit flag and the index of the winning slave.
module bus_decode #(
    parameter int              AW       = 16,
    parameter int              N        = 4,
    parameter int              IW       = 2,
    parameter logic [N*AW-1:0] SLV_BASE = '0,
    parameter logic [N*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric: decoded strobes, one outstanding read,
// and error responses for unmapped accesses and stalled slaves.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int              W        = 32,
    parameter int              AW       = 16,
    parameter int              N        = 4,
    parameter logic [N*AW-1:0] SLV_BASE = DEF_BASE,
    parameter logic [N*AW-1:0] SLV_MASK = DEF_MASK,
    parameter int              TIMEOUT  = 15,
    parameter logic [W-1:0]    ERR_DATA = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [AW-1:0]  m_addr,
    input  logic           m_ren,
    input  logic           m_wen,
    input  logic [W-1:0]   m_wdata,
    input  logic [W/8-1:0] m_wmask,
    output logic [W-1:0]   m_rdata,
    output logic           m_rd_valid,
    output logic           m_err,
    output logic [AW-1:0]  s_addr,
    output logic [W-1:0]   s_wdata,
    output logic [W/8-1:0] s_wmask,
    output logic [N-1:0]   s_ren,
    output logic [N-1:0]   s_wen,
    input  logic [N*W-1:0] s_rdata,
    input  logic [N-1:0]   s_rd_valid
);

    localparam int CW = cnt_w(TIMEOUT);
    localparam int IW = idx_w(N);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic          hit;
    logic [IW-1:0] idx;

    state_t        state, state_nx;
    logic [IW-1:0] rd_sel, rd_sel_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          err_q, err_nx;
    logic          err_rd_q, err_rd_nx;

    logic          rd_go;
    logic          sel_valid;
    logic [W-1:0]  sel_data;

    bus_decode #(
        .AW       (AW),
        .N        (N),
        .IW       (IW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (m_addr),
        .hit  (hit),
        .idx  (idx)
    );

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wmask = m_wmask;

    assign sel_valid = s_rd_valid[rd_sel];
    assign sel_data  = s_rdata[int'(rd_sel)*W +: W];

    // A read is only accepted when idle and not colliding with a write.
    assign rd_go = m_ren && !m_wen && (state == ST_IDLE);

    always_comb begin
        s_ren = '0;
        s_wen = '0;
        if (rd_go && hit) s_ren[idx] = 1'b1;
        if (m_wen && hit) s_wen[idx] = 1'b1;
    end

    always_comb begin
        state_nx  = state;
        rd_sel_nx = rd_sel;
        cnt_nx    = cnt;
        err_nx    = 1'b0;
        err_rd_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rd_go && hit) begin
                    state_nx  = ST_WAIT;
                    rd_sel_nx = idx;
                    cnt_nx    = '0;
                end else if (rd_go) begin
                    err_nx    = 1'b1;
                    err_rd_nx = 1'b1;
                end
            end
            ST_WAIT: begin
                if (sel_valid) begin
                    state_nx = ST_IDLE;
                end else if (cnt == LAST) begin
                    state_nx  = ST_IDLE;
                    err_nx    = 1'b1;
                    err_rd_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Dropped traffic is flagged without a read completion.
        if (m_wen && !hit)                err_nx = 1'b1;
        if (m_ren && m_wen)               err_nx = 1'b1;
        if (m_ren && (state == ST_WAIT))  err_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_sel   <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            err_rd_q <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_sel   <= rd_sel_nx;
            cnt      <= cnt_nx;
            err_q    <= err_nx;
            err_rd_q <= err_rd_nx;
        end
    end

    always_comb begin
        m_err      = err_q;
        m_rd_valid = err_rd_q || ((state == ST_WAIT) && sel_valid);
        if (err_rd_q)               m_rdata = ERR_DATA;
        else if (state == ST_WAIT)  m_rdata = sel_data;
        else                        m_rdata = '0;
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Scenario tasks plus a randomized run against a transaction-level model.
// Map: 0 BRAM, 1 SPRAM, 2 LED, 3 UART, 4 overlap window at 0x01xx.
module tb_bus_fabric;

    localparam int W  = 32;
    localparam int AW = 16;
    localparam int N  = 5;
    localparam int T  = 4;
    localparam logic [W-1:0] ERR = 32'hDEAD_BEEF;

    localparam logic [N*AW-1:0] TB_BASE = {
        16'h0100, 16'h5000, 16'h4000, 16'h8000, 16'h0000
    };
    localparam logic [N*AW-1:0] TB_MASK = {
        16'hFF00, 16'hF000, 16'hF000, 16'h8000, 16'hC000
    };

    logic [AW-1:0] map_base [N] = '{16'h0000, 16'h8000, 16'h4000, 16'h5000, 16'h0100};
    logic [AW-1:0] map_mask [N] = '{16'hC000, 16'h8000, 16'hF000, 16'hF000, 16'hFF00};

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  m_addr;
    logic           m_ren;
    logic           m_wen;
    logic [W-1:0]   m_wdata;
    logic [W/8-1:0] m_wmask;
    logic [W-1:0]   m_rdata;
    logic           m_rd_valid;
    logic           m_err;
    logic [AW-1:0]  s_addr;
    logic [W-1:0]   s_wdata;
    logic [W/8-1:0] s_wmask;
    logic [N-1:0]   s_ren;
    logic [N-1:0]   s_wen;
    logic [N*W-1:0] s_rdata;
    logic [N-1:0]   s_rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    bus_fabric #(
        .W        (W),
        .AW       (AW),
        .N        (N),
        .SLV_BASE (TB_BASE),
        .SLV_MASK (TB_MASK),
        .TIMEOUT  (T),
        .ERR_DATA (ERR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_addr     (m_addr),
        .m_ren      (m_ren),
        .m_wen      (m_wen),
        .m_wdata    (m_wdata),
        .m_wmask    (m_wmask),
        .m_rdata    (m_rdata),
        .m_rd_valid (m_rd_valid),
        .m_err      (m_err),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wmask    (s_wmask),
        .s_ren      (s_ren),
        .s_wen      (s_wen),
        .s_rdata    (s_rdata),
        .s_rd_valid (s_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m_ren      = 1'b0;
        m_wen      = 1'b0;
        s_rd_valid = '0;
    endtask

    function automatic int model_dec(input logic [AW-1:0] a);
        for (int i = 0; i < N; i++)
            if ((a & map_mask[i]) == map_base[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        s_rdata = '0;
        idle_in();
        cyc(); cyc();
        n_checks++;
        if (m_rd_valid !== 1'b0 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got v=%0b e=%0b exp 0 0", m_rd_valid, m_err);
        end
        n_checks++;
        if (m_rdata !== '0 || s_ren !== '0 || s_wen !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got d=%h ren=%b wen=%b exp 0", m_rdata, s_ren, s_wen);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_mapped_read();
        m_addr = 16'h0010; m_ren = 1'b1;
        #1;
        n_checks++;
        if (s_ren !== 5'b00001 || m_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL map_sren got %b v=%0b exp 00001 0", s_ren, m_rd_valid);
        end
        cyc();
        m_ren = 1'b0;
        s_rdata[0 +: W] = 32'h1234_5678;
        s_rd_valid = 5'b00001;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b1 || m_rdata !== 32'h1234_5678 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL map_done got v=%0b d=%h e=%0b exp 1 12345678 0",
                     m_rd_valid, m_rdata, m_err);
        end
        cyc();
        s_rd_valid = '0;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b0 || m_rdata !== '0) begin
            n_fail++;
            $display("FAIL map_after got v=%0b d=%h exp 0 0", m_rd_valid, m_rdata);
        end
        cyc();
    endtask

    task automatic test_unmapped();
        m_addr = 16'h6000; m_ren = 1'b1;
        #1;
        n_checks++;
        if (s_ren !== '0) begin
            n_fail++;
            $display("FAIL unm_sren got %b exp 0", s_ren);
        end
        cyc();
        m_ren = 1'b0;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== ERR) begin
            n_fail++;
            $display("FAIL unm_rd got v=%0b e=%0b d=%h exp 1 1 %h",
                     m_rd_valid, m_err, m_rdata, ERR);
        end
        cyc();
        m_wen = 1'b1; m_wdata = 32'hA5A5_0000; m_wmask = 4'hF;
        #1;
        n_checks++;
        if (s_wen !== '0) begin
            n_fail++;
            $display("FAIL unm_swen got %b exp 0", s_wen);
        end
        cyc();
        m_wen = 1'b0;
        #1;
        n_checks++;
        if (m_err !== 1'b1 || m_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unm_wr got e=%0b v=%0b exp 1 0", m_err, m_rd_valid);
        end
        cyc();
        n_checks++;
        if (m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL unm_clear got e=%0b exp 0", m_err);
        end
    endtask

    task automatic test_timeout();
        m_addr = 16'h5000; m_ren = 1'b1;
        cyc();
        m_ren = 1'b0;
        for (int k = 1; k <= T; k++) begin
            n_checks++;
            if (m_rd_valid !== 1'b0 || m_err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_early cyc %0d got v=%0b e=%0b exp 0 0",
                         k, m_rd_valid, m_err);
            end
            cyc();
        end
        n_checks++;
        if (m_rd_valid !== 1'b1 || m_err !== 1'b1 || m_rdata !== ERR) begin
            n_fail++;
            $display("FAIL to_done got v=%0b e=%0b d=%h exp 1 1 %h",
                     m_rd_valid, m_err, m_rdata, ERR);
        end
        cyc();
        s_rdata[3*W +: W] = 32'h0BAD_0BAD;
        s_rd_valid = 5'b01000;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b0 || m_rdata !== '0) begin
            n_fail++;
            $display("FAIL to_late got v=%0b d=%h exp 0 0", m_rd_valid, m_rdata);
        end
        cyc();
        s_rd_valid = '0;
    endtask

    task automatic test_priority();
        m_addr = 16'h0100; m_ren = 1'b1;
        #1;
        n_checks++;
        if (s_ren !== 5'b00001) begin
            n_fail++;
            $display("FAIL prio_ren got %b exp 00001", s_ren);
        end
        cyc();
        m_ren = 1'b0;
        s_rd_valid = 5'b00001;
        cyc();
        s_rd_valid = '0;
        m_wen = 1'b1;
        #1;
        n_checks++;
        if (s_wen !== 5'b00001) begin
            n_fail++;
            $display("FAIL prio_wen got %b exp 00001", s_wen);
        end
        cyc();
        m_wen = 1'b0;
        cyc();
    endtask

    task automatic test_stray();
        m_addr = 16'h5004; m_ren = 1'b1;
        cyc();
        m_ren = 1'b0;
        m_addr = 16'h4000;
        s_rdata[2*W +: W] = 32'h0000_00FF;
        s_rd_valid = 5'b00100;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_led got v=%0b exp 0", m_rd_valid);
        end
        cyc();
        s_rdata[3*W +: W] = 32'hCAFE_0001;
        s_rd_valid = 5'b01000;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b1 || m_rdata !== 32'hCAFE_0001 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_uart got v=%0b d=%h e=%0b exp 1 cafe0001 0",
                     m_rd_valid, m_rdata, m_err);
        end
        cyc();
        s_rd_valid = '0;
    endtask

    task automatic test_back_to_back();
        m_addr = 16'h0010; m_ren = 1'b1;
        cyc();
        m_ren = 1'b0;
        s_rdata[0 +: W] = 32'h1111_2222;
        s_rd_valid = 5'b00001;
        cyc();
        s_rd_valid = '0;
        m_addr = 16'h5008; m_ren = 1'b1;
        #1;
        n_checks++;
        if (s_ren !== 5'b01000) begin
            n_fail++;
            $display("FAIL b2b_ren got %b exp 01000", s_ren);
        end
        cyc();
        m_ren = 1'b0;
        s_rdata[3*W +: W] = 32'h3333_4444;
        s_rd_valid = 5'b01000;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b1 || m_rdata !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL b2b_done got v=%0b d=%h exp 1 33334444", m_rd_valid, m_rdata);
        end
        cyc();
        s_rd_valid = '0;
    endtask

    task automatic test_reset_mid_wait();
        m_addr = 16'h8004; m_ren = 1'b1;
        cyc();
        m_ren = 1'b0;
        s_rdata[1*W +: W] = 32'h7777_8888;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b0 || m_err !== 1'b0 || m_rdata !== '0) begin
            n_fail++;
            $display("FAIL rstw_outs got v=%0b e=%0b d=%h exp 0 0 0",
                     m_rd_valid, m_err, m_rdata);
        end
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        s_rd_valid = 5'b00010;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_late got v=%0b exp 0", m_rd_valid);
        end
        cyc();
        s_rd_valid = '0;
        m_ren = 1'b1;
        #1;
        n_checks++;
        if (s_ren !== 5'b00010) begin
            n_fail++;
            $display("FAIL rstw_ren got %b exp 00010", s_ren);
        end
        cyc();
        m_ren = 1'b0;
        s_rdata[1*W +: W] = 32'h5A5A_A5A5;
        s_rd_valid = 5'b00010;
        #1;
        n_checks++;
        if (m_rd_valid !== 1'b1 || m_rdata !== 32'h5A5A_A5A5 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_done got v=%0b d=%h e=%0b exp 1 5a5aa5a5 0",
                     m_rd_valid, m_rdata, m_err);
        end
        cyc();
        s_rd_valid = '0;
        cyc();
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [8] = '{16'h0010, 16'h0100, 16'h8004, 16'h4000,
                                     16'h5008, 16'h6000, 16'hF000, 16'h7000};
        bit            busy = 0;
        int            sel  = 0;
        int            age  = 0;
        bit            en   = 0;
        bit            er   = 0;
        bit            nen, ner;
        int            k;
        logic [N-1:0]  e_ren, e_wen;
        logic          e_v;
        logic [W-1:0]  e_d;
        idle_in();
        cyc(); cyc();
        for (int c = 0; c < 600; c++) begin
            m_addr  = pool[$urandom_range(0, 7)];
            m_ren   = ($urandom_range(0, 9) < 3);
            m_wen   = ($urandom_range(0, 9) < 2);
            m_wdata = $urandom;
            m_wmask = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                s_rdata[i*W +: W] = $urandom;
                s_rd_valid[i]     = ($urandom_range(0, 3) == 0);
            end
            #1;
            k = model_dec(m_addr);
            e_ren = '0;
            e_wen = '0;
            if (!busy && m_ren && !m_wen && k >= 0) e_ren[k] = 1'b1;
            if (m_wen && k >= 0) e_wen[k] = 1'b1;
            e_v = er || (busy && s_rd_valid[sel]);
            e_d = er ? ERR : (busy ? s_rdata[sel*W +: W] : '0);
            n_checks++;
            if (s_ren !== e_ren || s_wen !== e_wen) begin
                n_fail++;
                $display("FAIL rnd_strb c%0d got ren=%b wen=%b exp %b %b",
                         c, s_ren, s_wen, e_ren, e_wen);
            end
            n_checks++;
            if (m_rd_valid !== e_v || m_err !== en) begin
                n_fail++;
                $display("FAIL rnd_flag c%0d got v=%0b e=%0b exp %0b %0b",
                         c, m_rd_valid, m_err, e_v, en);
            end
            n_checks++;
            if (m_rdata !== e_d) begin
                n_fail++;
                $display("FAIL rnd_data c%0d got %h exp %h", c, m_rdata, e_d);
            end
            n_checks++;
            if (s_addr !== m_addr || s_wdata !== m_wdata || s_wmask !== m_wmask) begin
                n_fail++;
                $display("FAIL rnd_bcast c%0d got a=%h exp %h", c, s_addr, m_addr);
            end
            nen = (m_ren && (busy || m_wen || k < 0)) || (m_wen && k < 0);
            ner = !busy && m_ren && !m_wen && k < 0;
            if (busy) begin
                if (s_rd_valid[sel]) begin
                    busy = 0;
                end else if (age == T) begin
                    busy = 0;
                    nen  = 1;
                    ner  = 1;
                end else begin
                    age++;
                end
            end else if (m_ren && !m_wen && k >= 0) begin
                busy = 1;
                sel  = k;
                age  = 1;
            end
            en = nen;
            er = ner;
            cyc();
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_mapped_read();
        test_unmapped();
        test_timeout();
        test_priority();
        test_stray();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
